// File: rtl/pipe_adder.sv
// Segmented carry-pipelined adder/subtractor with valid/ready handshake and global stall.
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NSTG = WIDTH / SEG_W;
    localparam logic [WIDTH-1:0] ONES = '1;

    logic             en;

    // Inputs seen by each stage: stage 0 from the ports, stage k from register k-1
    logic [WIDTH-1:0] a_in [NSTG];
    logic [WIDTH-1:0] b_in [NSTG];
    logic [WIDTH-1:0] s_in [NSTG];
    logic             c_in [NSTG];
    logic             v_in [NSTG];
    logic [SEG_W:0]   seg_r [NSTG];

    logic [WIDTH-1:0] a_d [NSTG];
    logic [WIDTH-1:0] a_q [NSTG];
    logic [WIDTH-1:0] b_d [NSTG];
    logic [WIDTH-1:0] b_q [NSTG];
    logic [WIDTH-1:0] s_d [NSTG];
    logic [WIDTH-1:0] s_q [NSTG];
    logic             c_d [NSTG];
    logic             c_q [NSTG];
    logic             v_d [NSTG];
    logic             v_q [NSTG];

    assign out_valid = v_q[NSTG-1];
    assign sum       = s_q[NSTG-1];
    assign cout      = c_q[NSTG-1];
    assign in_ready  = !(out_valid && !out_ready);
    assign en        = in_ready;

    // Subtraction is folded in at entry (b inverted, carry forced to 1), so only
    // the effective operand and carry need to travel down the pipe.
    always_comb begin
        a_in[0] = a;
        b_in[0] = sub ? ~b : b;
        c_in[0] = sub | cin;
        s_in[0] = '0;
        v_in[0] = in_valid;
        for (int unsigned k = 1; k < NSTG; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    // Operands keep only the segments still to be added; sums keep only finished segments.
    always_comb begin
        for (int unsigned k = 0; k < NSTG; k++) begin
            seg_r[k] = (SEG_W+1)'(a_in[k][k*SEG_W +: SEG_W])
                     + (SEG_W+1)'(b_in[k][k*SEG_W +: SEG_W])
                     + (SEG_W+1)'(c_in[k]);
            a_d[k]   = a_in[k] & (ONES << ((k + 1) * SEG_W));
            b_d[k]   = b_in[k] & (ONES << ((k + 1) * SEG_W));
            s_d[k]   = s_in[k] | (WIDTH'(seg_r[k][SEG_W-1:0]) << (k * SEG_W));
            c_d[k]   = seg_r[k][SEG_W];
            v_d[k]   = v_in[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NSTG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else if (en) begin
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
            c_q <= c_d;
            v_q <= v_d;
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Overflow when both effective operands share a sign that the result does not.
    always_comb begin
        ovf_d = (a_in[NSTG-1][WIDTH-1] == b_in[NSTG-1][WIDTH-1])
             && (seg_r[NSTG-1][SEG_W-1] != a_in[NSTG-1][WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=16, SEG_W=4): directed vectors, stall, reset, random traffic.
module tb_pipe_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef PIPE_ADDER_OVF_EN
    logic        ovf;
`endif

    pipe_adder #(.WIDTH(16), .SEG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   bp_mode = 0;
    bit   bg_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Back-pressure driver: changes out_ready away from the sampling edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: a transfer happens at the next rising edge when out_valid && out_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", {15'd0, cout, sum}, 32'hDEAD);
                end else begin
                    e = q.pop_front();
                    chk("sum", {16'd0, sum}, {16'd0, e.s});
                    chk("cout", {31'd0, cout}, {31'd0, e.c});
`ifdef PIPE_ADDER_OVF_EN
                    chk("ovf", {31'd0, ovf}, {31'd0, e.o});
`endif
                    if (e.lat) chk("latency", (cyc + 1) - e.acc, 32'd4);
                end
            end
        end
    end

    task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic ts, input logic [15:0] es, input logic ec,
                        input logic eo, input bit lat);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        cin = tc;
        sub = ts;
        n = 0;
        while (!in_ready) begin
            @(negedge clk);
            n++;
            if (n > 1000) begin
                chk("in_ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        e.s = es;
        e.c = ec;
        e.o = eo;
        e.acc = cyc + 1;
        e.lat = lat;
        q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                              input logic ts);
        logic [16:0] full;
        int          r;
        if (ts) begin
            full = {1'b0, ta} + {1'b0, ~tb_} + 17'd1;
            r = int'($signed(ta)) - int'($signed(tb_));
        end else begin
            full = {1'b0, ta} + {1'b0, tb_} + 17'(tc);
            r = int'($signed(ta)) + int'($signed(tb_)) + int'(tc);
        end
        send(ta, tb_, tc, ts, full[15:0], full[16], (r > 32767) || (r < -32768), 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
                chk("drain_timeout", q.size(), 32'd0);
                q.delete();
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // First transaction, latency checked
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        drain();

        // Back-to-back, consecutive outputs via latency check
        send(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        send(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        drain();

        // Subtraction, carry ripple across segments, cin ignored when subtracting
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        send(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        send(16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        send(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        send(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        drain();

        // Output stall with 6 transactions offered
        bp_mode = 1;
        @(posedge clk);
        #3;
        bg_done = 1'b0;
        fork
            begin
                send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
                send(16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
                send(16'h0F00, 16'h0100, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
                send(16'hF000, 16'h1000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
                send(16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
                send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
                bg_done = 1'b1;
            end
        join_none
        repeat (5) @(negedge clk);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_head_sum", {16'd0, sum}, 32'h0003);
        repeat (3) @(negedge clk);
        chk("stall_held_sum", {16'd0, sum}, 32'h0003);
        chk("stall_queue", q.size(), 32'd4);
        bp_mode = 0;
        n = 0;
        while (!bg_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("stall_sender_done", {31'd0, bg_done}, 32'd1);
        drain();

        // Reset in mid-flight
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum", {16'd0, sum}, 32'd0);
        chk("midrst_cout", {31'd0, cout}, 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale_out", {31'd0, out_valid}, 32'd0);
        end
        send(16'h4321, 16'h1234, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
        drain();

        // Random traffic with bubbles and back-pressure
        bp_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
            send_model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        bp_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits, legal range 4..64.
REQ-002 Parameter SEG_W, default 4: bits per pipeline stage; WIDTH SHALL be a multiple of SEG_W, and NSTG = WIDTH/SEG_W.
REQ-003 clk  in  1  single clock, all flops rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  operands present this cycle.
REQ-006 in_ready  out  1  block accepts the operands this cycle.
REQ-007 a, b  in  WIDTH  operands.
REQ-008 cin  in  1  carry-in, used in add mode only.
REQ-009 sub  in  1  0 = a+b+cin; 1 = a-b (a + ~b + 1, cin ignored).
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 sum  out  WIDTH  result, all segments from the same transaction.
REQ-013 cout  out  1  carry out of the MSB segment (in sub mode, 1 means no borrow).

Function
REQ-014 The block SHALL be a linear pipeline of NSTG stages; stage k adds bits [k*SEG_W +: SEG_W] using the registered carry from stage k-1.
REQ-015 Transfer at input: in_valid && in_ready on a rising edge; transfer at output: out_valid && out_ready on a rising edge.
REQ-016 in_ready SHALL equal !(out_valid && !out_ready), combinationally.
REQ-017 When in_ready=0, every pipeline register SHALL hold its value (global stall); no transaction SHALL be dropped or duplicated.
REQ-018 When not stalled, the pipeline SHALL advance one stage per clock, and bubbles (in_valid=0) SHALL propagate as invalid slots.
REQ-019 Latency SHALL be exactly NSTG cycles with no stalls: accepted at edge t means out_valid at edge t+NSTG.
REQ-020 Upper operand segments SHALL be skew-delayed, and lower sum segments deskew-delayed, so sum and cout reflect one transaction.
REQ-021 Throughput SHALL be one transaction per clock when out_ready=1.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH, with the carry out of bit WIDTH-1 reported on cout.
REQ-023 sub and cin SHALL be sampled with the operands and travel with the transaction.
REQ-024 With NSTG=1, the block SHALL be a single registered adder with latency 1.

Reset
REQ-025 While rst_n=0, all valid flags SHALL be 0, and sum, cout and all carry and data registers SHALL be 0.
REQ-026 Asserting rst_n mid-operation SHALL discard all in-flight transactions; no partial result SHALL appear after release.
REQ-027 After rst_n deasserts, in_ready SHALL be 1, and the first accepted transaction SHALL appear NSTG cycles later.

Configuration
REQ-028 Macro PIPE_ADDER_OVF_EN: when defined, the block SHALL add output ovf (1 bit), the signed two's-complement overflow of the result for the selected mode, aligned with sum and reset to 0.
REQ-029 When PIPE_ADDER_OVF_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (WIDTH=16, SEG_W=4)
REQ-030 Reset, then a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later out_valid=1, sum=0x0000, cout=1.
REQ-031 Back-to-back: 0x1234+0x1111, 0x8000+0x8000, 0x0F0F+0xF0F0 with cin=1, out_ready=1 -> sums 0x2345/c0, 0x0000/c1, 0x0000/c1 on consecutive cycles.
REQ-032 sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; with OVF_EN, a=0x8000, b=0x0001 -> ovf=1.
REQ-033 Hold out_ready=0 for 5 cycles with 6 transactions offered -> in_ready drops, pipeline holds, and all 6 results emerge in order after out_ready=1.
REQ-034 Assert rst_n=0 two cycles after 3 transactions are accepted -> out_valid stays 0 until new input arrives, and no stale result appears.
REQ-035 Random regression, 10k transactions with random bubbles and back-pressure -> scoreboard matches an (a+b) model exactly.
